// File: rtl/fetch_issue_unit_if.sv
// fetch_issue_unit_if
//   Bundles the instruction-memory port, the redirect port and the issue
//   handshake of the fetch/issue front end.
//   master : the fetch unit (drives im_rd/im_addr, issue_*, halted)
//   slave  : the surroundings (memory, control unit, redirect source)
//   Signals:
//     im_rd, im_addr          fetch request and word address
//     im_valid, im_rdata      in-order returned instruction word
//     redirect_valid/pc       one-cycle flush plus new PC
//     issue_valid/ready       head-of-queue handshake toward the control unit
//     opcode, instr, issue_pc head instruction, its opcode and fetch address
//     halted                  a HALT was issued and fetching has stopped
interface fetch_issue_unit_if #(
  parameter int PC_W = 8
);
  logic            im_rd;
  logic [PC_W-1:0] im_addr;
  logic            im_valid;
  logic [31:0]     im_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            issue_valid;
  logic            issue_ready;
  logic [5:0]      opcode;
  logic [31:0]     instr;
  logic [PC_W-1:0] issue_pc;
  logic            halted;

  modport master (
    output im_rd, im_addr,
    input  im_valid, im_rdata,
    input  redirect_valid, redirect_pc,
    output issue_valid,
    input  issue_ready,
    output opcode, instr, issue_pc, halted
  );

  modport slave (
    input  im_rd, im_addr,
    output im_valid, im_rdata,
    output redirect_valid, redirect_pc,
    input  issue_valid,
    output issue_ready,
    input  opcode, instr, issue_pc, halted
  );
endinterface

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
//   Front end of the RISC CPU. Owns the PC, requests words from instruction
//   memory, keeps them in a small in-order prefetch queue and offers the head
//   to the control unit over valid/ready. A redirect flushes everything and
//   reloads the PC; issuing a HALT opcode stops fetching until a redirect.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    fetch_issue_unit_if.master (memory, redirect and issue signals)
//   Parameters:
//     PC_W     PC / word-address width
//     DEPTH    queue entries and maximum requests in flight (power of 2, >=2)
//     RESET_PC PC loaded on reset
//     HALT_OP  opcode (instr[31:26]) that halts fetching once issued
module fetch_issue_unit #(
  parameter int PC_W     = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int HALT_OP  = 63
) (
  input logic                clk,
  input logic                reset,
  fetch_issue_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_W-1:0] RESET_PC_V = RESET_PC[PC_W-1:0];
  localparam logic [5:0]      HALT_OP_V  = HALT_OP[5:0];
  localparam logic [CW:0]     DEPTH_V    = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT_PEND,
    S_HALTED
  } state_t;

  state_t          r_state;
  logic            r_halted;
  logic [PC_W-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_qWr;
  logic [AW-1:0]   r_qRd;
  logic [AW-1:0]   r_aWr;
  logic [AW-1:0]   r_aRd;
  logic [31:0]     r_qInstr [DEPTH];
  logic [PC_W-1:0] r_qPc    [DEPTH];
  logic [PC_W-1:0] r_aPc    [DEPTH];

  logic            w_xfer;
  logic            w_headHalt;
  logic            w_haltXfer;
  logic            w_flush;
  logic            w_drop;
  logic            w_push;
  logic            w_rd;
  logic [CW:0]     w_occupancy;
  logic [CW-1:0]   w_countNext;
  logic [CW-1:0]   w_discardNext;

  // Queue occupancy plus outstanding requests is the credit that keeps the
  // queue from ever overflowing, so a request is only made below DEPTH.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_rd = !reset && (r_state == S_RUN) && !bus.redirect_valid
                && (w_occupancy < DEPTH_V);

  assign w_xfer     = bus.issue_valid && bus.issue_ready;
  assign w_headHalt = (r_qInstr[r_qRd][31:26] == HALT_OP_V);
  assign w_haltXfer = w_xfer && w_headHalt && !bus.redirect_valid;
  // Both a redirect and an issued HALT throw away the queue and every
  // word still on its way back from memory.
  assign w_flush    = bus.redirect_valid || w_haltXfer;
  assign w_drop     = bus.im_valid && (r_discard != '0);
  assign w_push     = bus.im_valid && !w_drop && !w_flush;

  assign bus.im_rd       = w_rd;
  assign bus.im_addr     = r_pc;
  assign bus.issue_valid = (r_count != '0);
  assign bus.opcode      = r_qInstr[r_qRd][31:26];
  assign bus.instr       = r_qInstr[r_qRd];
  assign bus.issue_pc    = r_qPc[r_qRd];
  assign bus.halted      = r_halted;

  // Next queue count and discard budget. On a flush every request still
  // outstanding after this cycle must be dropped, which is exactly the
  // in-flight count minus a word returning right now; that already covers
  // any discards left over from an earlier flush.
  always_comb begin
    w_countNext   = r_count;
    w_discardNext = r_discard;
    if (w_flush) begin
      w_countNext   = '0;
      w_discardNext = r_inflight - CW'(bus.im_valid);
    end else begin
      w_countNext = r_count + CW'(w_push) - CW'(w_xfer);
      if (w_drop) begin
        w_discardNext = r_discard - CW'(1);
      end
    end
  end

  // PC, request bookkeeping and queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC_V;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_qWr      <= '0;
      r_qRd      <= '0;
      r_aWr      <= '0;
      r_aRd      <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_rd) - CW'(bus.im_valid);
      r_discard  <= w_discardNext;
      r_count    <= w_countNext;
      if (bus.redirect_valid) begin
        r_pc <= bus.redirect_pc;
      end else if (w_rd) begin
        r_pc <= r_pc + PC_W'(1);
      end
      // The address FIFO tracks every outstanding request, dropped or not,
      // so it advances on each request and each return regardless of flush.
      if (w_rd) begin
        r_aWr <= r_aWr + AW'(1);
      end
      if (bus.im_valid) begin
        r_aRd <= r_aRd + AW'(1);
      end
      if (w_flush) begin
        r_qRd <= r_qWr;
      end else begin
        if (w_push) begin
          r_qWr <= r_qWr + AW'(1);
        end
        if (w_xfer) begin
          r_qRd <= r_qRd + AW'(1);
        end
      end
    end
  end

  // Storage for the queue entries and the fetch-address FIFO. Entries are
  // cleared on reset so the issue outputs read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_qInstr[i] <= '0;
        r_qPc[i]    <= '0;
        r_aPc[i]    <= '0;
      end
    end else begin
      if (w_rd) begin
        r_aPc[r_aWr] <= r_pc;
      end
      if (w_push) begin
        r_qInstr[r_qWr] <= bus.im_rdata;
        r_qPc[r_qWr]    <= r_aPc[r_aRd];
      end
    end
  end

  // Halt control: a pushed HALT stops new requests, issuing it halts the
  // front end, and only a redirect (or reset) starts it running again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        r_state  <= S_RUN;
        r_halted <= 1'b0;
      end else if (w_haltXfer) begin
        r_state  <= S_HALTED;
        r_halted <= 1'b1;
      end else if (w_push && (bus.im_rdata[31:26] == HALT_OP_V)
                   && (r_state == S_RUN)) begin
        r_state <= S_HALT_PEND;
      end
    end
  end

endmodule
